// File: rtl/addseq_arb_pkg.sv
// Shared definitions for the time-multiplexed wide adder (addseq_arb_module).
// Holds the FSM state encoding used by the top level.
package addseq_arb_pkg;

  // Two-bit controller state: waiting for a request, stepping through
  // beats on the shared adder, and the one-cycle completion state.
  typedef enum logic [1:0] {
    ADDSEQ_IDLE = 2'd0,
    ADDSEQ_BUSY = 2'd1,
    ADDSEQ_DONE = 2'd2
  } addseq_state_e;

endpackage

// File: rtl/addcinen_module.sv
// Adder with carry-in and optional operand isolation.
// Ports:
//   en   in  1      adder enable; with OPIS=1 all inputs are forced to 0 when low
//   a    in  WIDTH  operand A
//   b    in  WIDTH  operand B
//   cin  in  1      carry-in
//   q    out WIDTH  a + b + cin (modulo 2^WIDTH)
module addcinen_module #(
  parameter int WIDTH = 17,
  parameter int OPIS  = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] a_g;
  logic [WIDTH-1:0] b_g;
  logic             cin_g;

  // Operand isolation keeps the adder inputs quiet while it is not in use,
  // so toggling on the source registers does not ripple through the adder.
  generate
    if (OPIS != 0) begin : g_isolate
      assign a_g   = en ? a : '0;
      assign b_g   = en ? b : '0;
      assign cin_g = en & cin;
    end else begin : g_pass
      assign a_g   = a;
      assign b_g   = b;
      assign cin_g = cin;
    end
  endgenerate

  // Plain ripple-style add; the caller widens operands by one bit to
  // recover the carry-out from the top bit of q.
  assign q = a_g + b_g + WIDTH'(cin_g);

endmodule

// File: rtl/addseq_arb_module.sv
// Time-multiplexed wide adder. NREQ requesters share one CHUNK-bit adder;
// each granted request computes a WIDTH-bit a+b+cin over NBEAT=WIDTH/CHUNK
// beats, chaining the carry between beats. Round-robin arbitration.
// Ports:
//   clk   in  1           clock, all state on rising edge
//   rst   in  1           asynchronous active-low reset
//   req   in  NREQ        per-requester request, held until ack
//   cin   in  NREQ        per-requester carry-in
//   a     in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   b     in  NREQ*WIDTH  operand B, same packing
//   ack   out NREQ        one-hot single-cycle completion pulse
//   q     out WIDTH       sum, valid while any ack bit is high
//   cout  out 1           carry out of bit WIDTH-1, valid with ack
//   busy  out 1           high while in BUSY or DONE
// WIDTH must be a multiple of CHUNK.
module addseq_arb_module
  import addseq_arb_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int NREQ  = 2,
  parameter int OPIS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       cin,
  input  logic [NREQ*WIDTH-1:0] a,
  input  logic [NREQ*WIDTH-1:0] b,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  cout,
  output logic                  busy
);

  localparam int NBEAT  = WIDTH / CHUNK;
  localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NREQ - 1);

  addseq_state_e     state;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic              carry;
  logic [ID_W-1:0]   id;
  logic [ID_W-1:0]   rr_ptr;
  logic [BEAT_W-1:0] beat;

  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W:0]     cand;

  logic              adder_en;
  logic [CHUNK-1:0]  opa_chunk;
  logic [CHUNK-1:0]  opb_chunk;
  logic [CHUNK:0]    sum;

  // Round-robin pick: walk offsets from the highest down to zero so the
  // requester closest to (at or above) rr_ptr is the last one written and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (cand >= (ID_W + 1)'(NREQ)) begin
        cand = cand - (ID_W + 1)'(NREQ);
      end
      if (req[cand[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  // Slice of the captured operands that the current beat works on.
  assign opa_chunk = opa[int'(beat) * CHUNK +: CHUNK];
  assign opb_chunk = opb[int'(beat) * CHUNK +: CHUNK];
  assign adder_en  = (state == ADDSEQ_BUSY);

  // Shared adder, one bit wider than a chunk so its top bit is the beat carry.
  addcinen_module #(
    .WIDTH (CHUNK + 1),
    .OPIS  (OPIS)
  ) u_add (
    .en  (adder_en),
    .a   ({1'b0, opa_chunk}),
    .b   ({1'b0, opb_chunk}),
    .cin (carry),
    .q   (sum)
  );

  assign busy = (state == ADDSEQ_BUSY) || (state == ADDSEQ_DONE);

  // Controller: capture the winner in IDLE, accumulate one chunk per beat in
  // BUSY, then release in DONE. ack is registered off the DONE state, so the
  // pulse shows up in the cycle after DONE, when q/cout are already final and
  // the FSM is back in IDLE; this keeps a new op every NBEAT+2 cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ADDSEQ_IDLE;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      id     <= '0;
      rr_ptr <= '0;
      beat   <= '0;
      ack    <= '0;
      q      <= '0;
      cout   <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        ADDSEQ_IDLE: begin
          if (grant_valid) begin
            opa   <= a[int'(grant_id) * WIDTH +: WIDTH];
            opb   <= b[int'(grant_id) * WIDTH +: WIDTH];
            carry <= cin[grant_id];
            id    <= grant_id;
            beat  <= '0;
            state <= ADDSEQ_BUSY;
          end
        end
        ADDSEQ_BUSY: begin
          q[int'(beat) * CHUNK +: CHUNK] <= sum[CHUNK-1:0];
          carry <= sum[CHUNK];
          beat  <= beat + 1'b1;
          if (beat == LAST_BEAT) begin
            cout  <= sum[CHUNK];
            state <= ADDSEQ_DONE;
          end
        end
        ADDSEQ_DONE: begin
          for (int i = 0; i < NREQ; i++) begin
            ack[i] <= (id == ID_W'(i));
          end
          rr_ptr <= (id == LAST_ID) ? '0 : id + 1'b1;
          state  <= ADDSEQ_IDLE;
        end
        default: begin
          state <= ADDSEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addseq_arb_module.sv
// Scoreboard bench for addseq_arb_module: stimulus pushes expected
// {ack, q, cout, ack cycle} records, a negedge monitor pops and compares
// whenever ack is high. A second instance covers the single-beat config.
module tb_addseq_arb_module;

  localparam int WIDTH = 64;
  localparam int NREQ  = 2;
  localparam int NBEAT = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       cin;
  logic [NREQ*WIDTH-1:0] a;
  logic [NREQ*WIDTH-1:0] b;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  cout;
  logic                  busy;

  logic [NREQ-1:0]       req1;
  logic [NREQ-1:0]       cin1;
  logic [NREQ*WIDTH-1:0] a1;
  logic [NREQ*WIDTH-1:0] b1;
  logic [NREQ-1:0]       ack1;
  logic [WIDTH-1:0]      q1;
  logic                  cout1;
  logic                  busy1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] q;
    logic             cout;
    int               due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  addseq_arb_module #(
    .WIDTH (WIDTH), .CHUNK (16), .NREQ (NREQ), .OPIS (1)
  ) dut (
    .clk (clk), .rst (rst), .req (req), .cin (cin), .a (a), .b (b),
    .ack (ack), .q (q), .cout (cout), .busy (busy)
  );

  addseq_arb_module #(
    .WIDTH (WIDTH), .CHUNK (64), .NREQ (NREQ), .OPIS (1)
  ) dut_nb1 (
    .clk (clk), .rst (rst), .req (req1), .cin (cin1), .a (a1), .b (b1),
    .ack (ack1), .q (q1), .cout (cout1), .busy (busy1)
  );

  // Free-running clock and a cycle counter that names each rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  task automatic pushExpected(input logic [NREQ-1:0] e_ack, input logic [WIDTH-1:0] e_q,
                              input logic e_cout, input int e_due);
    exp_t e;
    e.ack  = e_ack;
    e.q    = e_q;
    e.cout = e_cout;
    e.due  = e_due;
    sb.push_back(e);
  endtask

  task automatic driveReq(input int idx, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb, input logic vc);
    a[idx*WIDTH +: WIDTH] = va;
    b[idx*WIDTH +: WIDTH] = vb;
    cin[idx] = vc;
    req[idx] = 1'b1;
  endtask

  // Bounded wait for the requester's ack; drops its req in the ack cycle.
  task automatic waitAck(input int idx);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack[idx]) begin
        req[idx] = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("[TB] FAIL ack_timeout requester=%0d actual=no_ack required=ack", idx);
    req[idx] = 1'b0;
  endtask

  // One transaction on an idle DUT: grant edge is the next rising edge,
  // so ack is due NBEAT+2 counted edges later.
  task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] va,
                               input logic [WIDTH-1:0] vb, input logic vc,
                               input logic [WIDTH-1:0] eq, input logic ec);
    logic [NREQ-1:0] eack;
    @(negedge clk);
    eack = '0;
    eack[idx] = 1'b1;
    driveReq(idx, va, vb, vc);
    pushExpected(eack, eq, ec, cyc + NBEAT + 2);
    waitAck(idx);
  endtask

  // Single-beat instance: ack due three rising edges after the sample edge.
  task automatic runSingleBeat(input int idx, input logic [WIDTH-1:0] va,
                               input logic [WIDTH-1:0] vb, input logic vc,
                               input logic [WIDTH-1:0] eq, input logic ec);
    int c;
    logic [NREQ-1:0] eack;
    bit found;
    @(negedge clk);
    c = cyc;
    eack = '0;
    eack[idx] = 1'b1;
    a1[idx*WIDTH +: WIDTH] = va;
    b1[idx*WIDTH +: WIDTH] = vb;
    cin1[idx] = vc;
    req1[idx] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (|ack1) begin
        found = 1'b1;
        checkOutput("nb1_ack", WIDTH'(ack1), WIDTH'(eack));
        checkOutput("nb1_q", q1, eq);
        checkOutput("nb1_cout", WIDTH'(cout1), WIDTH'(ec));
        checkOutput("nb1_ack_cycle", WIDTH'(cyc), WIDTH'(c + 3));
        req1[idx] = 1'b0;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("[TB] FAIL nb1_ack_timeout actual=no_ack required=ack");
      req1[idx] = 1'b0;
    end
  endtask

  // Monitor: every ack pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (|ack) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_ack actual=%0b required=00", ack);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("ack_id", WIDTH'(ack), WIDTH'(mon_e.ack));
        checkOutput("sum_q", q, mon_e.q);
        checkOutput("sum_cout", WIDTH'(cout), WIDTH'(mon_e.cout));
        checkOutput("ack_cycle", WIDTH'(cyc), WIDTH'(mon_e.due));
      end
    end
  end

  initial begin
    int c;
    int acks_seen;
    int busy_low;

    req  = '0; cin  = '0; a  = '0; b  = '0;
    req1 = '0; cin1 = '0; a1 = '0; b1 = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", WIDTH'(ack), 64'h0);
    checkOutput("rst_q", q, 64'h0);
    checkOutput("rst_cout", WIDTH'(cout), 64'h0);
    checkOutput("rst_busy", WIDTH'(busy), 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // Carry ripples through all four beats.
    applyStimulus(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1);
    // Requester 1 with carry-in.
    applyStimulus(1, 64'h0000_0001_0000_FFFF, 64'h1, 1'b1,
                  64'h0000_0001_0001_0001, 1'b0);

    // Both requesting continuously: alternate grants, 6 cycles apart.
    @(negedge clk);
    c = cyc;
    driveReq(0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    driveReq(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    pushExpected(2'b01, 64'h2345_6789_ABCD_F001, 1'b0, c + 6);
    pushExpected(2'b10, 64'h0000_0000_0000_0001, 1'b1, c + 12);
    pushExpected(2'b01, 64'h2345_6789_ABCD_F001, 1'b0, c + 18);
    pushExpected(2'b10, 64'h0000_0000_0000_0001, 1'b1, c + 24);
    acks_seen = 0;
    busy_low  = 0;
    for (int n = 0; n < 60 && acks_seen < 4; n++) begin
      @(negedge clk);
      if (|ack) acks_seen++;
      if (acks_seen >= 1 && !busy) busy_low++;
    end
    req = '0;
    checkOutput("rr_ack_count", WIDTH'(acks_seen), 64'd4);
    checkOutput("busy_low_cycles", WIDTH'(busy_low), 64'd4);

    // Operands and req change right after grant; original sum still acked.
    @(negedge clk);
    c = cyc;
    driveReq(0, 64'h3, 64'h4, 1'b1);
    pushExpected(2'b01, 64'h8, 1'b0, c + 6);
    @(negedge clk);
    a[0 +: WIDTH] = 64'hFFFF_FFFF_FFFF_FFFF;
    b[0 +: WIDTH] = 64'hFFFF_FFFF_FFFF_FFFF;
    cin[0] = 1'b0;
    req[0] = 1'b0;
    waitAck(0);

    // Reset during beat 2 drops the op; req[1] served after release.
    @(negedge clk);
    driveReq(1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_ack", WIDTH'(ack), 64'h0);
    checkOutput("midrst_q", q, 64'h0);
    checkOutput("midrst_cout", WIDTH'(cout), 64'h0);
    checkOutput("midrst_busy", WIDTH'(busy), 64'h0);
    rst = 1'b1;
    c = cyc;
    pushExpected(2'b10, 64'h0000_0001_0000_0000, 1'b0, c + 6);
    waitAck(1);

    // Single-beat configuration.
    runSingleBeat(0, 64'd5, 64'd7, 1'b1, 64'd13, 1'b0);
    runSingleBeat(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", WIDTH'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
